// File: rtl/traffic_phase_controller_pkg.sv
// ---------------------------------------------------------------------------
// light_package
// Shared types and constants for the intersection phase controller.
//   colors         : per-head colour code. Red is zero, so any non-zero value
//                    means the head is showing something other than red.
//   phase_state_t  : controller sequencing states.
//   DEFAULT_PHASE_MAP : default phase-to-light masks for the 5-head layout
//                    [0]e_str [1]e_left [2]w_str [3]w_left [4]ns.
//                    P0 = lefts, P1 = straights, P2 = north/south.
//   max3()         : helper used to size the shared phase timer.
// ---------------------------------------------------------------------------
package light_package;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } colors;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_ALLRED = 2'd3
    } phase_state_t;

    // Element [2] is the leftmost literal: P2 = ns, P1 = straights, P0 = lefts.
    localparam logic [2:0][4:0] DEFAULT_PHASE_MAP = {5'b10000, 5'b00101, 5'b01010};

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/traffic_phase_controller_arbiter.sv
// ---------------------------------------------------------------------------
// phase_rr_arbiter
// Purely combinational rotate-priority search over phase demands.
// The search starts at ptr+1 and wraps modulo NUM_PHASES; ptr itself is
// examined last, so the phase that was just served has lowest priority.
//   dem         in  NUM_PHASES        per-phase demand
//   ptr         in  clog2(NUM_PHASES) last granted phase
//   grant       out clog2(NUM_PHASES) selected phase (0 when none)
//   grant_valid out 1                 some phase is demanding
// ---------------------------------------------------------------------------
module phase_rr_arbiter #(
    parameter int NUM_PHASES = 3
) (
    input  logic [NUM_PHASES-1:0]         dem,
    input  logic [$clog2(NUM_PHASES)-1:0] ptr,
    output logic [$clog2(NUM_PHASES)-1:0] grant,
    output logic                          grant_valid
);

    localparam int PW = $clog2(NUM_PHASES);

    // (p + off) mod NUM_PHASES for off in 1..NUM_PHASES without a divider.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= NUM_PHASES) s = s - NUM_PHASES;
        return PW'(s);
    endfunction

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        // Walk from the farthest candidate to the nearest so the last hit,
        // which overwrites earlier ones, is the closest phase after ptr.
        for (int i = NUM_PHASES; i >= 1; i--) begin
            if (dem[wrap_idx(ptr, i)]) begin
                grant       = wrap_idx(ptr, i);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// ---------------------------------------------------------------------------
// traffic_phase_controller
// Serves NUM_PHASES mutually exclusive signal phases round-robin with
// min-green, forced rotation at max-green, gap-out, timed yellow and
// all-red clearance. All outputs decode from registered state only.
//   clk          in  1                  system clock (rising edge)
//   reset        in  1                  synchronous active-high, all-red idle
//   sensor       in  NUM_LIGHTS         per-light demand
//   lights       out NUM_LIGHTS x 2     per-light colour (light_package::colors)
//   active_phase out clog2(NUM_PHASES)  phase currently green/yellow
//   phase_valid  out 1                  high in GREEN and YELLOW
// ---------------------------------------------------------------------------
module traffic_phase_controller
    import light_package::*;
#(
    parameter int NUM_LIGHTS  = 5,
    parameter int NUM_PHASES  = 3,
    parameter logic [NUM_PHASES-1:0][NUM_LIGHTS-1:0] PHASE_MAP = DEFAULT_PHASE_MAP,
    parameter int MIN_GREEN   = 5,
    parameter int MAX_GREEN   = 10,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_LIGHTS-1:0]             sensor,
    output logic [NUM_LIGHTS-1:0][1:0]        lights,
    output logic [$clog2(NUM_PHASES)-1:0]     active_phase,
    output logic                              phase_valid
);

    localparam int PW = $clog2(NUM_PHASES);
    // One timer is reused for green, yellow and all-red, so it must hold the
    // largest of the three counts.
    localparam int TW = $clog2(max3(MAX_GREEN, YELLOW_TIME, ALLRED_TIME) + 1);

    localparam logic [1:0] ST_IDLE   = PH_IDLE;
    localparam logic [1:0] ST_GREEN  = PH_GREEN;
    localparam logic [1:0] ST_YELLOW = PH_YELLOW;
    localparam logic [1:0] ST_ALLRED = PH_ALLRED;

    localparam logic [TW-1:0] T_MIN_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_MAX_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] T_MAX      = TW'(MAX_GREEN);
    localparam logic [TW-1:0] T_Y_LAST   = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] T_R_LAST   = TW'(ALLRED_TIME - 1);

    logic [1:0]            state_q,  state_d;
    logic [TW-1:0]         timer_q,  timer_d;
    logic [PW-1:0]         active_q, active_d;
    logic [PW-1:0]         ptr_q,    ptr_d;

    logic [NUM_PHASES-1:0] dem;
    logic [PW-1:0]         grant;
    logic                  grant_valid;
    logic                  own_dem;
    logic                  other_dem;
    logic [TW-1:0]         timer_inc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_dem
            assign dem[gi] = |(sensor & PHASE_MAP[gi]);
        end
    endgenerate

    assign own_dem   = dem[active_q];
    assign other_dem = |(dem & ~(NUM_PHASES'(1) << active_q));
    // Saturates at MAX_GREEN so an indefinite rest in green never wraps.
    assign timer_inc = (timer_q >= T_MAX) ? timer_q : timer_q + TW'(1);

    phase_rr_arbiter #(
        .NUM_PHASES (NUM_PHASES)
    ) u_arb (
        .dem         (dem),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        active_d = active_q;
        ptr_d    = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d  = ST_GREEN;
                    timer_d  = '0;
                    active_d = grant;
                    ptr_d    = grant;
                end
            end
            ST_GREEN: begin
                timer_d = timer_inc;
                // Leave only for a conflicting demand; own demand keeps the
                // phase up to max-green, its absence gaps out after min-green.
                if (timer_q >= T_MIN_LAST && other_dem &&
                    (!own_dem || timer_q >= T_MAX_LAST)) begin
                    state_d = ST_YELLOW;
                    timer_d = '0;
                end
            end
            ST_YELLOW: begin
                timer_d = timer_inc;
                if (timer_q == T_Y_LAST) begin
                    state_d = ST_ALLRED;
                    timer_d = '0;
                end
            end
            default: begin // ST_ALLRED
                timer_d = timer_inc;
                if (timer_q == T_R_LAST) begin
                    timer_d = '0;
                    if (grant_valid) begin
                        state_d  = ST_GREEN;
                        active_d = grant;
                        ptr_d    = grant;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            active_q <= '0;
            ptr_q    <= PW'(NUM_PHASES - 1);
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            active_q <= active_d;
            ptr_q    <= ptr_d;
        end
    end

    assign phase_valid  = (state_q == ST_GREEN) || (state_q == ST_YELLOW);
    assign active_phase = active_q;

    generate
        for (gi = 0; gi < NUM_LIGHTS; gi++) begin : g_lamp
            logic lit;
            assign lit        = phase_valid && PHASE_MAP[active_q][gi];
            assign lights[gi] = !lit                   ? RED   :
                                (state_q == ST_GREEN)  ? GREEN : YELLOW;
        end
    endgenerate

endmodule

// File: tb/tb_traffic_phase_controller.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_controller
// Directed scenarios for traffic_phase_controller. The driver applies one
// input vector per cycle and queues the hand-derived response expected after
// the next rising edge; an independent monitor pops and compares one entry
// per cycle and also checks that no head outside the active phase mask is lit.
// ---------------------------------------------------------------------------
module tb_traffic_phase_controller;
    import light_package::*;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       sensor;
    logic [4:0][1:0]  lights;
    logic [1:0]       active_phase;
    logic             phase_valid;

    always #5 clk = ~clk;

    traffic_phase_controller dut (
        .clk          (clk),
        .reset        (reset),
        .sensor       (sensor),
        .lights       (lights),
        .active_phase (active_phase),
        .phase_valid  (phase_valid)
    );

    localparam logic [2:0][4:0] MAP = {5'b10000, 5'b00101, 5'b01010};

    localparam int K_RST = 0; // all red, active_phase 0, phase_valid 0
    localparam int K_RED = 1; // all red, phase_valid 0, active_phase don't care
    localparam int K_GRN = 2;
    localparam int K_YEL = 3;

    typedef struct packed {
        logic [4:0][1:0] lt;
        logic [1:0]      act;
        logic            care_act;
        logic            vld;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    function automatic exp_t mk(input int kind, input int ph);
        exp_t e;
        e.lt       = '0;
        e.act      = 2'(ph);
        e.care_act = 1'b1;
        e.vld      = 1'b0;
        if (kind == K_RST) begin
            e.act = 2'd0;
        end else if (kind == K_RED) begin
            e.care_act = 1'b0;
        end else begin
            e.vld = 1'b1;
            for (int i = 0; i < 5; i++)
                if (MAP[ph][i]) e.lt[i] = (kind == K_GRN) ? 2'b10 : 2'b01;
        end
        return e;
    endfunction

    task automatic drive(input logic r, input logic [4:0] s, input int kind,
                         input int ph, input string tag);
        @(negedge clk);
        reset  = r;
        sensor = s;
        sb_q.push_back(mk(kind, ph));
        tag_q.push_back(tag);
    endtask

    task automatic run(input logic r, input logic [4:0] s, input int kind,
                       input int ph, input int n, input string tag);
        repeat (n) drive(r, s, kind, ph, tag);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    exp_t  m_e;
    string m_t;
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 5; i++) begin
            if (lights[i] != 2'b00 &&
                (!phase_valid || active_phase > 2'd2 || !MAP[active_phase][i])) begin
                n_bad++;
                $display("FAIL invariant: light %0d shows %b with active_phase=%0d phase_valid=%b, required 00",
                         i, lights[i], active_phase, phase_valid);
            end
        end
        if (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            m_t = tag_q.pop_front();
            n_vec++;
            if (lights !== m_e.lt || phase_valid !== m_e.vld ||
                (m_e.care_act && active_phase !== m_e.act)) begin
                n_bad++;
                $display("FAIL %s (vec %0d): lights=%b act=%0d valid=%b, required lights=%b act=%0d%s valid=%b",
                         m_t, n_vec, lights, active_phase, phase_valid,
                         m_e.lt, m_e.act, m_e.care_act ? "" : "(any)", m_e.vld);
            end else begin
                $display("vec %0d %s lights=%b act=%0d valid=%b", n_vec, m_t,
                         lights, active_phase, phase_valid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        sensor = 5'b00000;

        // Reset held with every sensor high, then full rotation 0,1,2,0.
        run(1'b1, 5'b11111, K_RST, 0, 3,  "reset_hold");
        run(1'b0, 5'b11111, K_GRN, 0, 10, "rot_p0_green");
        run(1'b0, 5'b11111, K_YEL, 0, 2,  "rot_p0_yellow");
        run(1'b0, 5'b11111, K_RED, 0, 1,  "rot_p0_allred");
        run(1'b0, 5'b11111, K_GRN, 1, 10, "rot_p1_green");
        run(1'b0, 5'b11111, K_YEL, 1, 2,  "rot_p1_yellow");
        run(1'b0, 5'b11111, K_RED, 0, 1,  "rot_p1_allred");
        run(1'b0, 5'b11111, K_GRN, 2, 10, "rot_p2_green");
        run(1'b0, 5'b11111, K_YEL, 2, 2,  "rot_p2_yellow");
        run(1'b0, 5'b11111, K_RED, 0, 1,  "rot_p2_allred");
        run(1'b0, 5'b11111, K_GRN, 0, 1,  "rot_wrap_p0");

        // Idle without demand, then a one-cycle ns pulse rests in green.
        run(1'b1, 5'b00000, K_RST, 0, 2,  "reset_idle");
        run(1'b0, 5'b00000, K_RST, 0, 1,  "idle_no_demand");
        run(1'b0, 5'b10000, K_GRN, 2, 1,  "ns_pulse_grant");
        run(1'b0, 5'b00000, K_GRN, 2, 50, "ns_rest");

        // ns gaps out at min-green once e_left is waiting.
        run(1'b1, 5'b00000, K_RST, 0, 1,  "reset_s3");
        run(1'b0, 5'b10000, K_GRN, 2, 1,  "s3_ns_grant");
        run(1'b0, 5'b00010, K_GRN, 2, 4,  "s3_ns_min_green");
        run(1'b0, 5'b00010, K_YEL, 2, 2,  "s3_ns_yellow");
        run(1'b0, 5'b00010, K_RED, 0, 1,  "s3_allred");
        run(1'b0, 5'b00010, K_GRN, 0, 2,  "s3_eleft_grant");

        // Straights green with ns waiting; straights drop at green cycle 7.
        run(1'b1, 5'b00000, K_RST, 0, 1,  "reset_s5");
        run(1'b0, 5'b00101, K_GRN, 1, 1,  "s5_p1_grant");
        run(1'b0, 5'b10101, K_GRN, 1, 6,  "s5_p1_held");
        run(1'b0, 5'b10000, K_YEL, 1, 2,  "s5_gap_yellow");
        run(1'b0, 5'b10000, K_RED, 0, 1,  "s5_allred");
        run(1'b0, 5'b10000, K_GRN, 2, 1,  "s5_ns_grant");

        // Reset during yellow, then ns alone is served again.
        run(1'b0, 5'b00010, K_GRN, 2, 4,  "s6_ns_min_green");
        run(1'b0, 5'b00010, K_YEL, 2, 1,  "s6_yellow1");
        run(1'b1, 5'b00010, K_RST, 0, 1,  "s6_reset_in_yellow");
        run(1'b0, 5'b10000, K_GRN, 2, 3,  "s6_post_reset_ns");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
